// File: rtl/conv_enc_if.sv
// Handshake bundle for the K=7 convolutional encoder: bit input stream and
// registered code-symbol output stream.
interface conv_enc_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_last;
  logic             sym_valid;
  logic             sym_ready;
  logic [1:0]       sym;
  logic             sym_tail;
  logic             sym_last;
  logic [CNT_W-1:0] sym_cnt;

  modport master (
    output in_valid, in_bit, in_last, sym_ready,
    input  in_ready, sym_valid, sym, sym_tail, sym_last, sym_cnt
  );

  modport slave (
    input  in_valid, in_bit, in_last, sym_ready,
    output in_ready, sym_valid, sym, sym_tail, sym_last, sym_cnt
  );
endinterface

// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 convolutional encoder with a single registered output stage
// and optional K-1 zero tail bits so the trellis terminates in state 0.
//
// state | meaning
// ENC   | accept input bits and encode them
// TAIL  | inject K-1 zero bits, no input accepted
module conv_encoder_k7 #(
  parameter int           K       = 7,
  parameter logic [K-1:0] G0      = 7'o171,
  parameter logic [K-1:0] G1      = 7'o133,
  parameter bit           TAIL_EN = 1'b1,
  parameter int           CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  output logic [K-2:0] state,
  conv_enc_if.slave    bus
);

  localparam int TC_W = $clog2(K);
  localparam logic [TC_W-1:0] TAIL_LAST = TC_W'(K - 2);

  typedef enum logic {ENC, TAIL} fsm_t;

  fsm_t             fsm_q, fsm_n;
  logic [K-2:0]     state_q, state_n;
  logic [TC_W-1:0]  tcnt_q, tcnt_n;
  logic             valid_q, valid_n;
  logic [1:0]       sym_q, sym_n;
  logic             tail_q, tail_n;
  logic             last_q, last_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             load, in_ready, accept, tail_step, enc_b;
  logic [K-1:0]     sr;
  logic [1:0]       code;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ENC;
      state_q <= '0;
      tcnt_q  <= '0;
      valid_q <= 1'b0;
      sym_q   <= '0;
      tail_q  <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_n;
      state_q <= state_n;
      tcnt_q  <= tcnt_n;
      valid_q <= valid_n;
      sym_q   <= sym_n;
      tail_q  <= tail_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    fsm_n   = fsm_q;
    state_n = state_q;
    tcnt_n  = tcnt_q;
    valid_n = valid_q;
    sym_n   = sym_q;
    tail_n  = tail_q;
    last_n  = last_q;
    cnt_n   = cnt_q;

    load      = !valid_q || bus.sym_ready;
    in_ready  = load && (fsm_q == ENC) && !clear;
    accept    = in_ready && bus.in_valid;
    tail_step = load && (fsm_q == TAIL) && !clear;
    enc_b     = (fsm_q == TAIL) ? 1'b0 : bus.in_bit;
    sr        = {enc_b, state_q};
    code      = {^(sr & G0), ^(sr & G1)};
    // last_q stays set until the next symbol loads, so it marks a frame restart
    if (last_q)
      cnt_inc = CNT_W'(1);
    else if (&cnt_q)
      cnt_inc = cnt_q;
    else
      cnt_inc = cnt_q + CNT_W'(1);

    if (clear) begin
      fsm_n   = ENC;
      state_n = '0;
      tcnt_n  = '0;
      valid_n = 1'b0;
      sym_n   = '0;
      tail_n  = 1'b0;
      last_n  = 1'b0;
      cnt_n   = '0;
    end else if (accept) begin
      valid_n = 1'b1;
      sym_n   = code;
      tail_n  = 1'b0;
      cnt_n   = cnt_inc;
      state_n = sr[K-1:1];
      last_n  = 1'b0;
      if (bus.in_last) begin
        if (TAIL_EN) begin
          fsm_n  = TAIL;
          tcnt_n = '0;
        end else begin
          last_n  = 1'b1;
          state_n = '0;
        end
      end
    end else if (tail_step) begin
      valid_n = 1'b1;
      sym_n   = code;
      tail_n  = 1'b1;
      cnt_n   = cnt_inc;
      state_n = sr[K-1:1];
      tcnt_n  = tcnt_q + TC_W'(1);
      last_n  = 1'b0;
      if (tcnt_q == TAIL_LAST) begin
        last_n = 1'b1;
        fsm_n  = ENC;
        tcnt_n = '0;
      end
    end else if (load) begin
      valid_n = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sym_valid = valid_q;
  assign bus.sym       = sym_q;
  assign bus.sym_tail  = tail_q;
  assign bus.sym_last  = last_q;
  assign bus.sym_cnt   = cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Directed bench for conv_encoder_k7: one instance with tail bits, one without.
module tb_conv_encoder_k7;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_t = 1'b0;
  logic       clear_n = 1'b0;
  logic [5:0] state_t, state_n;
  int         n_cmp = 0;
  int         n_err = 0;

  conv_enc_if #(.CNT_W(CNT_W)) ift ();
  conv_enc_if #(.CNT_W(CNT_W)) ifn ();

  conv_encoder_k7 #(.TAIL_EN(1'b1), .CNT_W(CNT_W)) dut_t (
    .clk(clk), .rst_n(rst_n), .clear(clear_t), .state(state_t), .bus(ift.slave)
  );
  conv_encoder_k7 #(.TAIL_EN(1'b0), .CNT_W(CNT_W)) dut_n (
    .clk(clk), .rst_n(rst_n), .clear(clear_n), .state(state_n), .bus(ifn.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // impulse response of (171,133): column i = taps of bit i below the MSB
  logic [1:0] imp [7] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
  // two back-to-back frames 1,0,1 and 0,1,1 each followed by 6 tail symbols
  logic [1:0] b2b [18] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11,
                           2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
  logic       b2b_bits [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int low_cnt;
    ift.in_valid = 0; ift.in_bit = 0; ift.in_last = 0; ift.sym_ready = 1;
    ifn.in_valid = 0; ifn.in_bit = 0; ifn.in_last = 0; ifn.sym_ready = 1;

    // reset values
    #1;
    check("rst_valid", ift.sym_valid, 0);
    check("rst_sym",   ift.sym, 0);
    check("rst_tail",  ift.sym_tail, 0);
    check("rst_last",  ift.sym_last, 0);
    check("rst_cnt",   ift.sym_cnt, 0);
    check("rst_state", state_t, 0);
    #12 rst_n = 1;
    tick();
    check("rst_ready", ift.in_ready, 1);

    // impulse with tail, continuous ready
    ift.in_valid = 1; ift.in_bit = 1; ift.in_last = 1;
    tick();
    ift.in_valid = 0; ift.in_last = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      check("imp_valid", ift.sym_valid, 1);
      check("imp_sym",   ift.sym, imp[i]);
      check("imp_tail",  ift.sym_tail, (i != 0));
      check("imp_last",  ift.sym_last, (i == 6));
      check("imp_cnt",   ift.sym_cnt, i + 1);
      if (i < 6) check("imp_ready_tail", ift.in_ready, 0);
    end
    check("imp_state_end", state_t, 0);
    tick();
    check("imp_idle", ift.sym_valid, 0);

    // backpressure after the 2nd symbol
    ift.in_valid = 1; ift.in_bit = 1; ift.in_last = 1;
    tick();
    ift.in_valid = 0; ift.in_last = 0;
    check("bp_cnt1", ift.sym_cnt, 1);
    tick();
    check("bp_sym2", ift.sym, imp[1]);
    ift.sym_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", ift.in_ready, 0);
      tick();
      check("bp_hold_valid", ift.sym_valid, 1);
      check("bp_hold_sym",   ift.sym, 2'b10);
      check("bp_hold_cnt",   ift.sym_cnt, 2);
    end
    ift.sym_ready = 1;
    for (int i = 2; i < 7; i++) begin
      tick();
      check("bp_sym",  ift.sym, imp[i]);
      check("bp_cnt",  ift.sym_cnt, i + 1);
      check("bp_last", ift.sym_last, (i == 6));
    end
    tick();

    // all-zero frame of 10 bits
    for (int k = 0; k < 16; k++) begin
      ift.in_valid = (k < 10);
      ift.in_bit = 0;
      ift.in_last = (k == 9);
      tick();
      check("zero_valid", ift.sym_valid, 1);
      check("zero_sym",   ift.sym, 0);
      check("zero_cnt",   ift.sym_cnt, k + 1);
      check("zero_last",  ift.sym_last, (k == 15));
    end
    ift.in_valid = 0; ift.in_last = 0;
    tick();

    // no-tail instance: bits 1,1
    ifn.in_valid = 1; ifn.in_bit = 1; ifn.in_last = 0;
    tick();
    check("nt_sym0",  ifn.sym, 2'b11);
    check("nt_last0", ifn.sym_last, 0);
    check("nt_cnt0",  ifn.sym_cnt, 1);
    ifn.in_last = 1;
    #1 check("nt_ready", ifn.in_ready, 1);
    tick();
    ifn.in_valid = 0; ifn.in_last = 0;
    check("nt_sym1",  ifn.sym, 2'b01);
    check("nt_last1", ifn.sym_last, 1);
    check("nt_cnt1",  ifn.sym_cnt, 2);
    check("nt_state", state_n, 0);
    tick();
    check("nt_idle", ifn.sym_valid, 0);
    ifn.in_valid = 1; ifn.in_bit = 1; ifn.in_last = 1;
    tick();
    ifn.in_valid = 0; ifn.in_last = 0;
    check("nt_next_sym", ifn.sym, 2'b11);
    check("nt_next_cnt", ifn.sym_cnt, 1);
    tick();

    // clear on the 3rd tail symbol
    ift.in_valid = 1; ift.in_bit = 1; ift.in_last = 1;
    tick();
    ift.in_valid = 0; ift.in_last = 0;
    tick(); tick(); tick();
    check("clr_pre_sym",  ift.sym, imp[3]);
    check("clr_pre_tail", ift.sym_tail, 1);
    clear_t = 1;
    #1 check("clr_ready", ift.in_ready, 0);
    tick();
    clear_t = 0;
    check("clr_valid", ift.sym_valid, 0);
    check("clr_state", state_t, 0);
    #1 check("clr_enc", ift.in_ready, 1);
    ift.in_valid = 1; ift.in_bit = 1; ift.in_last = 1;
    tick();
    ift.in_valid = 0; ift.in_last = 0;
    check("clr_next_sym", ift.sym, 2'b11);
    check("clr_next_cnt", ift.sym_cnt, 1);

    // reset mid-tail
    tick(); tick();
    rst_n = 0;
    #1;
    check("mrst_valid", ift.sym_valid, 0);
    check("mrst_state", state_t, 0);
    check("mrst_cnt",   ift.sym_cnt, 0);
    #2 rst_n = 1;
    #1 check("mrst_enc", ift.in_ready, 1);
    ift.in_valid = 1; ift.in_bit = 1; ift.in_last = 1;
    tick();
    ift.in_valid = 0; ift.in_last = 0;
    check("mrst_sym",  ift.sym, 2'b11);
    check("mrst_cnt1", ift.sym_cnt, 1);
    check("mrst_tail", ift.sym_tail, 0);
    for (int i = 1; i < 7; i++) tick();
    check("mrst_last", ift.sym_last, 1);
    check("mrst_end_state", state_t, 0);
    tick();

    // back-to-back frames, valid held high throughout
    low_cnt = 0;
    for (int c = 0; c < 18; c++) begin
      int d;
      d = (c < 3) ? c : ((c >= 9 && c < 12) ? c - 6 : 5);
      ift.in_valid = (c < 12);
      ift.in_bit = b2b_bits[d];
      ift.in_last = (d == 2 || d == 5);
      #1;
      if (c < 12) begin
        check("b2b_ready", ift.in_ready, (c < 3) || (c >= 9));
        if (!ift.in_ready) low_cnt++;
      end
      tick();
      check("b2b_valid", ift.sym_valid, 1);
      check("b2b_sym",   ift.sym, b2b[c]);
      check("b2b_cnt",   ift.sym_cnt, (c % 9) + 1);
      check("b2b_last",  ift.sym_last, (c == 8 || c == 17));
    end
    ift.in_valid = 0; ift.in_last = 0;
    check("b2b_low_cycles", low_cnt, 6);
    check("b2b_state", state_t, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
